// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-file constants and the legal mul/div latency range.
package hazard_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MD_RUN = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MD_LAT_MIN = 1;
    localparam int MD_LAT_MAX = 15;

endpackage

// File: rtl/hazard_event_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module hazard_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use stalls, EX-resolved
// redirects and multi-cycle mul/div occupancy, plus stall/flush counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_MulDiv,
    input  logic             EX_MemRead,
    input  logic             EX_RegWre,
    input  logic [4:0]       EX_WriteReg,
    input  logic             EX_PCSrc,
    output logic             PC_Wre,
    output logic             IF_ID_Wre,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Wre,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // A single-cycle mul/div needs no extra occupancy, so MD_RUN is unreachable.
    localparam bit         MD_MULTI = (MD_LATENCY > MD_LAT_MIN) && (MD_LATENCY <= MD_LAT_MAX);
    localparam logic [3:0] MD_LOAD  = 4'(MD_LATENCY - 1);

    state_t     state;
    logic [3:0] md_cnt;
    logic       load_use;
    logic       md_start;
    logic       stall_inc;
    logic       flush_inc;

    assign load_use = EX_MemRead && EX_RegWre && (EX_WriteReg != REG_ZERO) &&
                      ((ID_UseRs && (ID_rs == EX_WriteReg)) ||
                       (ID_UseRt && (ID_rt == EX_WriteReg)));

    assign md_start  = (state == ST_IDLE) && !EX_PCSrc && !load_use && ID_MulDiv && MD_MULTI;
    assign stall_inc = ((state == ST_IDLE) && !EX_PCSrc && load_use) || (state == ST_MD_RUN);
    assign flush_inc = (state == ST_IDLE) && EX_PCSrc;

    always_comb begin
        PC_Wre       = 1'b1;
        IF_ID_Wre    = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Wre    = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        Busy         = 1'b0;
        if (Reset) begin
            PC_Wre       = 1'b0;
            IF_ID_Wre    = 1'b0;
            ID_EX_Wre    = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (state == ST_MD_RUN) begin
            // EX is held by the mul/div; redirects and load-use wait for it.
            PC_Wre       = 1'b0;
            IF_ID_Wre    = 1'b0;
            ID_EX_Wre    = 1'b0;
            EX_MEM_Flush = 1'b1;
            Busy         = 1'b1;
        end else if (EX_PCSrc) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
        end else if (load_use) begin
            PC_Wre       = 1'b0;
            IF_ID_Wre    = 1'b0;
            ID_EX_Flush  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= ST_IDLE;
            md_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        state  <= ST_MD_RUN;
                        md_cnt <= MD_LOAD;
                    end
                end
                ST_MD_RUN: begin
                    md_cnt <= md_cnt - 4'd1;
                    if (md_cnt == 4'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    md_cnt <= 4'd0;
                end
            endcase
        end
    end

    hazard_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .clear (Reset),
        .inc   (stall_inc),
        .count (StallCount)
    );

    hazard_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .clear (Reset),
        .inc   (flush_inc),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-output scoreboard;
// a CNT_W=4 copy shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        Reset;
    logic [4:0]  ID_rs, ID_rt, EX_WriteReg;
    logic        ID_UseRs, ID_UseRt, ID_MulDiv, EX_MemRead, EX_RegWre, EX_PCSrc;
    logic        PC_Wre, IF_ID_Wre, IF_ID_Flush, ID_EX_Wre, ID_EX_Flush, EX_MEM_Flush, Busy;
    logic [15:0] StallCount, FlushCount;
    logic        s_PC_Wre, s_IF_ID_Wre, s_IF_ID_Flush, s_ID_EX_Wre, s_ID_EX_Flush, s_EX_MEM_Flush, s_Busy;
    logic [3:0]  s_StallCount, s_FlushCount;

    // Control vector order: PC_Wre, IF_ID_Wre, IF_ID_Flush, ID_EX_Wre, ID_EX_Flush, EX_MEM_Flush, Busy
    localparam logic [6:0] V_IDLE = 7'b1101000;
    localparam logic [6:0] V_LU   = 7'b0001100;
    localparam logic [6:0] V_BR   = 7'b1111100;
    localparam logic [6:0] V_MD   = 7'b0000011;
    localparam logic [6:0] V_RST  = 7'b0010110;

    typedef struct {
        logic [6:0]  ctrl;
        logic [15:0] stall;
        logic [15:0] flush;
        logic [3:0]  sat_stall;
        logic [3:0]  sat_flush;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    int e_stall = 0, e_flush = 0, e_sat_stall = 0, e_sat_flush = 0;

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_MulDiv(ID_MulDiv),
        .EX_MemRead(EX_MemRead), .EX_RegWre(EX_RegWre), .EX_WriteReg(EX_WriteReg),
        .EX_PCSrc(EX_PCSrc), .PC_Wre(PC_Wre), .IF_ID_Wre(IF_ID_Wre),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Wre(ID_EX_Wre), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Flush(EX_MEM_Flush), .Busy(Busy),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
        .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_MulDiv(ID_MulDiv),
        .EX_MemRead(EX_MemRead), .EX_RegWre(EX_RegWre), .EX_WriteReg(EX_WriteReg),
        .EX_PCSrc(EX_PCSrc), .PC_Wre(s_PC_Wre), .IF_ID_Wre(s_IF_ID_Wre),
        .IF_ID_Flush(s_IF_ID_Flush), .ID_EX_Wre(s_ID_EX_Wre), .ID_EX_Flush(s_ID_EX_Flush),
        .EX_MEM_Flush(s_EX_MEM_Flush), .Busy(s_Busy),
        .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic md,
                       input logic mr, input logic rw, input logic [4:0] wr,
                       input logic pcs, input logic [6:0] ev, input string tag);
        exp_t e;
        @(posedge CLK);
        #1;
        Reset = rst; ID_rs = rs; ID_rt = rt; ID_UseRs = urs; ID_UseRt = urt;
        ID_MulDiv = md; EX_MemRead = mr; EX_RegWre = rw; EX_WriteReg = wr; EX_PCSrc = pcs;
        e.ctrl      = ev;
        e.stall     = 16'(e_stall);
        e.flush     = 16'(e_flush);
        e.sat_stall = 4'(e_sat_stall);
        e.sat_flush = 4'(e_sat_flush);
        e.tag       = tag;
        exp_q.push_back(e);
        @(negedge CLK);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard empty observed=- expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".ctrl"}, 32'({PC_Wre, IF_ID_Wre, IF_ID_Flush, ID_EX_Wre,
                                         ID_EX_Flush, EX_MEM_Flush, Busy}), 32'(e.ctrl));
            check({e.tag, ".stall"}, 32'(StallCount), 32'(e.stall));
            check({e.tag, ".flush"}, 32'(FlushCount), 32'(e.flush));
            check({e.tag, ".sat_stall"}, 32'(s_StallCount), 32'(e.sat_stall));
            check({e.tag, ".sat_flush"}, 32'(s_FlushCount), 32'(e.sat_flush));
        end
        // Counter effects of this cycle become visible after the next edge.
        if (rst) begin
            e_stall = 0; e_flush = 0; e_sat_stall = 0; e_sat_flush = 0;
        end else begin
            if (!ev[6]) begin
                if (e_stall < 65535) e_stall++;
                if (e_sat_stall < 15) e_sat_stall++;
            end
            if (ev[4]) begin
                if (e_flush < 65535) e_flush++;
                if (e_sat_flush < 15) e_sat_flush++;
            end
        end
    endtask

    initial begin
        Reset = 1'b1; ID_rs = '0; ID_rt = '0; ID_UseRs = 0; ID_UseRt = 0; ID_MulDiv = 0;
        EX_MemRead = 0; EX_RegWre = 0; EX_WriteReg = '0; EX_PCSrc = 0;

        //  rst rs     rt     urs urt md mr rw wr     pcs expected tag
        cyc(1, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_RST,  "reset0");
        cyc(1, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_RST,  "reset1");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_IDLE, "idle0");

        cyc(0, 5'd8,  5'd0,  1,  0,  0, 1, 1, 5'd8,  0,  V_LU,   "lu_rs");
        cyc(0, 5'd8,  5'd0,  1,  0,  0, 0, 1, 5'd8,  0,  V_IDLE, "lu_rs_after");
        cyc(0, 5'd0,  5'd0,  1,  0,  0, 1, 1, 5'd0,  0,  V_IDLE, "lu_r0");
        cyc(0, 5'd1,  5'd5,  0,  1,  0, 1, 1, 5'd5,  0,  V_LU,   "lu_rt");
        cyc(0, 5'd5,  5'd5,  0,  0,  0, 1, 1, 5'd5,  0,  V_IDLE, "lu_nouse");
        cyc(0, 5'd7,  5'd0,  1,  0,  0, 1, 0, 5'd7,  0,  V_IDLE, "lu_noregwre");

        cyc(0, 5'd8,  5'd0,  1,  0,  0, 1, 1, 5'd8,  1,  V_BR,   "br_lu");
        cyc(0, 5'd0,  5'd0,  0,  0,  1, 0, 0, 5'd0,  1,  V_BR,   "br_md");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_IDLE, "br_after");

        cyc(0, 5'd0,  5'd0,  0,  0,  1, 0, 0, 5'd0,  0,  V_IDLE, "md_t0");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_MD,   "md_t1");
        cyc(0, 5'd8,  5'd0,  1,  0,  0, 1, 1, 5'd8,  1,  V_MD,   "md_t2_br");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_MD,   "md_t3");
        cyc(0, 5'd0,  5'd0,  0,  0,  1, 0, 0, 5'd0,  0,  V_IDLE, "md_t4_b2b");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_MD,   "md2_t1");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_MD,   "md2_t2");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_MD,   "md2_t3");
        cyc(0, 5'd3,  5'd0,  1,  0,  0, 1, 1, 5'd3,  0,  V_LU,   "md2_exit_lu");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_IDLE, "md2_idle");

        cyc(0, 5'd0,  5'd0,  0,  0,  1, 0, 0, 5'd0,  0,  V_IDLE, "mdr_t0");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_MD,   "mdr_t1");
        cyc(1, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_RST,  "mdr_t2_rst");
        cyc(1, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_RST,  "mdr_t3_rst");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_IDLE, "mdr_t4_idle");
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_IDLE, "mdr_t5_idle");

        for (int i = 0; i < 20; i++) begin
            cyc(0, 5'd9, 5'd0, 1, 0, 0, 1, 1, 5'd9, 0, V_LU,   "sat_lu");
            cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, V_IDLE, "sat_gap");
        end
        for (int i = 0; i < 17; i++) begin
            cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, V_BR,   "sat_br");
        end
        cyc(0, 5'd0,  5'd0,  0,  0,  0, 0, 0, 5'd0,  0,  V_IDLE, "sat_final");
        check("sat_stall_allones", 32'(s_StallCount), 32'hF);
        check("sat_flush_allones", 32'(s_FlushCount), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It sits beside the EX-stage bypass logic and sequences the pipeline registers (PC, IF/ID, ID/EX, EX/MEM) so the following work correctly:
- load-use dependencies that bypassing cannot cover;
- taken branches/jumps resolved in EX;
- multi-cycle mul/div instructions that occupy EX for several cycles.

It also keeps saturating stall and flush performance counters.

Parameters:
MD_LATENCY, 4, total EX-stage occupancy in cycles of a mul/div instruction; legal range 1..15.
CNT_W, 16, width of each performance counter.

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_UseRs  in  1  ID instruction reads rs
ID_UseRt  in  1  ID instruction reads rt
ID_MulDiv  in  1  ID instruction is multi-cycle mul/div
EX_MemRead  in  1  EX instruction is a load
EX_RegWre  in  1  EX instruction writes the register file
EX_WriteReg  in  5  destination register of the EX instruction
EX_PCSrc  in  1  branch/jump in EX is taken (redirect)
PC_Wre  out  1  PC load enable
IF_ID_Wre  out  1  IF/ID register load enable
IF_ID_Flush  out  1  IF/ID register loads a bubble
ID_EX_Wre  out  1  ID/EX register load enable
ID_EX_Flush  out  1  ID/EX register loads a bubble
EX_MEM_Flush  out  1  EX/MEM register loads a bubble
Busy  out  1  mul/div sequence in progress
StallCount  out  CNT_W  cycles with PC_Wre=0 caused by hazards
FlushCount  out  CNT_W  taken-redirect events

Behaviour:
- FSM states: IDLE and MD_RUN. There is a 4-bit down-counter md_cnt. Control outputs are combinational from state and inputs. Counters are registered.
- LoadUse = EX_MemRead & EX_RegWre & (EX_WriteReg != 0) & ((ID_UseRs & ID_rs == EX_WriteReg) | (ID_UseRt & ID_rt == EX_WriteReg)).
- Defaults in IDLE: PC_Wre=1, IF_ID_Wre=1, ID_EX_Wre=1, all flushes 0, Busy=0.
- Priority in IDLE, highest first:
  1. EX_PCSrc=1: IF_ID_Flush=1, ID_EX_Flush=1, PC_Wre=1. LoadUse and ID_MulDiv are ignored because the ID instruction is squashed.
  2. LoadUse=1: PC_Wre=0, IF_ID_Wre=0, ID_EX_Flush=1, for exactly one cycle per occurrence.
  3. ID_MulDiv=1 with MD_LATENCY>1: the instruction advances normally. On that edge, state goes to MD_RUN and md_cnt loads MD_LATENCY-1.
- With MD_LATENCY=1, MD_RUN is never entered.
- MD_RUN:
  - Outputs: PC_Wre=0, IF_ID_Wre=0, ID_EX_Wre=0, EX_MEM_Flush=1, Busy=1, other flushes 0.
  - EX_PCSrc and LoadUse are ignored (EX holds the mul/div).
  - md_cnt decrements each cycle. When md_cnt==1, the next state is IDLE.
  - MD_RUN therefore lasts MD_LATENCY-1 cycles. In the following IDLE cycle the held instruction's result passes into EX/MEM normally.
- StallCount: +1 on each cycle where (IDLE & !EX_PCSrc & LoadUse) or MD_RUN. Saturates at all-ones.
- FlushCount: +1 on each IDLE cycle with EX_PCSrc=1. Saturates at all-ones.
- Reset=1, taking effect at the edge and also while asserted:
  - State goes to IDLE, md_cnt=0, both counters 0.
  - While Reset is high: PC_Wre=0, IF_ID_Wre=0, ID_EX_Wre=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1, Busy=0.
  - Reset during MD_RUN abandons the sequence. The first cycle after Reset deasserts is IDLE.
- Back-to-back mul/div: the second enters MD_RUN in its own right after the first leaves. A load-use on the ID instruction after MD_RUN stalls normally in the first IDLE cycle.

Decomposition:
- Shared package hazard_pkg holds:
  - the state typedef/localparams (ST_IDLE=1'b0, ST_MD_RUN=1'b1);
  - REG_ZERO=5'd0;
  - the MD_LATENCY legal bounds.
- One sub-module, hazard_event_counter: a CNT_W-bit saturating counter with synchronous clear and an inc input. It is instantiated twice, for stalls and flushes.

Test Plan:
- Load-use: EX_MemRead=1, EX_RegWre=1, EX_WriteReg=8, ID_rs=8, ID_UseRs=1 for one cycle -> PC_Wre=0, IF_ID_Wre=0, ID_EX_Flush=1 for that cycle only; StallCount 0->1. Repeat with EX_WriteReg=0 -> no stall.
- Taken branch with coincident load-use inputs: EX_PCSrc=1, LoadUse true -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Wre=1; FlushCount +1; StallCount unchanged.
- Mul/div, MD_LATENCY=4: ID_MulDiv=1 at cycle t -> Busy=1, EX_MEM_Flush=1, ID_EX_Wre=0 in cycles t+1..t+3; IDLE at t+4 with all enables 1; StallCount +3.
- EX_PCSrc=1 asserted in cycle t+2 during MD_RUN -> ignored: no flush outputs, FlushCount unchanged, exit still at t+4.
- Reset asserted in cycle t+2 of MD_RUN -> cycle t+3: Busy=0, both counters 0, all three flushes=1; after deassert, IDLE defaults.
- Saturation: with CNT_W=4, force 20 load-use stalls -> StallCount holds 4'hF.
